// File: rtl/hid_keycode_rx.sv
// HID boot-protocol keyboard report receiver.
// Collects an 8-byte report, filters phantom/short/long/stalled reports.
module hid_keycode_rx #(
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [7:0] byte_in,
    input  logic       byte_valid,
    input  logic       byte_last,
    output logic       byte_ready,
    output logic [7:0] keycode_0,
    output logic [7:0] keycode_1,
    output logic [7:0] keycode_2,
    output logic [7:0] keycode_3,
    output logic [7:0] modifier,
    output logic       report_strobe,
    output logic       report_err
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] COLLECT = 2'd1;
    localparam logic [1:0] DRAIN   = 2'd2;
    localparam logic [1:0] REPORT  = 2'd3;

    localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]    state;
    logic [2:0]    idx;
    logic [TW-1:0] tcnt;
    logic [7:0]    sh_mod;
    logic [7:0]    sh_k0;
    logic [7:0]    sh_k1;
    logic [7:0]    sh_k2;
    logic [7:0]    sh_k3;

    logic accept;
    logic waiting;
    logic timeout;
    logic phantom;

    assign byte_ready = (state != REPORT);
    assign accept     = byte_valid & byte_ready;
    assign waiting    = (state == COLLECT) || (state == DRAIN);
    assign timeout    = waiting && (tcnt == TW'(TIMEOUT_CYCLES));

    // Keyboard rollover: every slot reports ErrorRollOver.
    assign phantom = (sh_k0 == 8'h01) && (sh_k1 == 8'h01) &&
                     (sh_k2 == 8'h01) && (sh_k3 == 8'h01);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state         <= IDLE;
            idx           <= 3'd0;
            tcnt          <= '0;
            sh_mod        <= 8'h00;
            sh_k0         <= 8'h00;
            sh_k1         <= 8'h00;
            sh_k2         <= 8'h00;
            sh_k3         <= 8'h00;
            modifier      <= 8'h00;
            keycode_0     <= 8'h00;
            keycode_1     <= 8'h00;
            keycode_2     <= 8'h00;
            keycode_3     <= 8'h00;
            report_strobe <= 1'b0;
            report_err    <= 1'b0;
        end else begin
            report_strobe <= 1'b0;
            report_err    <= 1'b0;
            if (timeout) begin
                // A byte landing on the abort cycle opens a fresh report.
                report_err <= 1'b1;
                tcnt       <= '0;
                if (accept && !byte_last) begin
                    sh_mod <= byte_in;
                    idx    <= 3'd1;
                    state  <= COLLECT;
                end else begin
                    if (accept) begin
                        sh_mod <= byte_in;
                    end
                    idx   <= 3'd0;
                    state <= IDLE;
                end
            end else begin
                unique case (state)
                    IDLE: begin
                        tcnt <= '0;
                        if (accept) begin
                            sh_mod <= byte_in;
                            if (byte_last) begin
                                report_err <= 1'b1;
                                idx        <= 3'd0;
                            end else begin
                                idx   <= 3'd1;
                                state <= COLLECT;
                            end
                        end
                    end
                    COLLECT: begin
                        if (accept) begin
                            tcnt <= '0;
                            idx  <= idx + 3'd1;
                            case (idx)
                                3'd2:    sh_k0 <= byte_in;
                                3'd3:    sh_k1 <= byte_in;
                                3'd4:    sh_k2 <= byte_in;
                                3'd5:    sh_k3 <= byte_in;
                                default: ;
                            endcase
                            if (byte_last) begin
                                idx <= 3'd0;
                                if (idx == 3'd7) begin
                                    state <= REPORT;
                                end else begin
                                    report_err <= 1'b1;
                                    state      <= IDLE;
                                end
                            end else if (idx == 3'd7) begin
                                state <= DRAIN;
                            end
                        end else begin
                            tcnt <= tcnt + TW'(1);
                        end
                    end
                    DRAIN: begin
                        if (accept) begin
                            tcnt <= '0;
                            if (byte_last) begin
                                report_err <= 1'b1;
                                idx        <= 3'd0;
                                state      <= IDLE;
                            end
                        end else begin
                            tcnt <= tcnt + TW'(1);
                        end
                    end
                    REPORT: begin
                        if (phantom) begin
                            report_err <= 1'b1;
                        end else begin
                            modifier      <= sh_mod;
                            keycode_0     <= sh_k0;
                            keycode_1     <= sh_k1;
                            keycode_2     <= sh_k2;
                            keycode_3     <= sh_k3;
                            report_strobe <= 1'b1;
                        end
                        tcnt  <= '0;
                        idx   <= 3'd0;
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hid_keycode_rx.sv
// Directed bench for hid_keycode_rx: good, phantom, short, long,
// timeout and mid-report reset scenarios.
module tb_hid_keycode_rx;

    localparam int TO = 12;

    logic       Clk;
    logic       Reset;
    logic [7:0] byte_in;
    logic       byte_valid;
    logic       byte_last;
    logic       byte_ready;
    logic [7:0] keycode_0;
    logic [7:0] keycode_1;
    logic [7:0] keycode_2;
    logic [7:0] keycode_3;
    logic [7:0] modifier;
    logic       report_strobe;
    logic       report_err;

    int vectors;
    int miscompares;
    int strobe_cnt;
    int err_cnt;
    int both_cnt;

    hid_keycode_rx #(.TIMEOUT_CYCLES(TO)) dut (
        .Clk(Clk),
        .Reset(Reset),
        .byte_in(byte_in),
        .byte_valid(byte_valid),
        .byte_last(byte_last),
        .byte_ready(byte_ready),
        .keycode_0(keycode_0),
        .keycode_1(keycode_1),
        .keycode_2(keycode_2),
        .keycode_3(keycode_3),
        .modifier(modifier),
        .report_strobe(report_strobe),
        .report_err(report_err)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(negedge Clk) begin
        if (report_strobe === 1'b1) strobe_cnt++;
        if (report_err === 1'b1) err_cnt++;
        if (report_strobe === 1'b1 && report_err === 1'b1) both_cnt++;
    end

    task automatic check8(input string tag, input logic [7:0] obs,
                          input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkn(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic l);
        int w;
        w = 0;
        while (byte_ready !== 1'b1 && w < 8) begin
            cycles(1);
            w++;
        end
        check8("ready_wait", {7'd0, byte_ready}, 8'h01);
        byte_in    = b;
        byte_valid = 1'b1;
        byte_last  = l;
        cycles(1);
        byte_valid = 1'b0;
        byte_last  = 1'b0;
    endtask

    task automatic send8(input logic [7:0] a0, input logic [7:0] a1,
                         input logic [7:0] a2, input logic [7:0] a3,
                         input logic [7:0] a4, input logic [7:0] a5,
                         input logic [7:0] a6, input logic [7:0] a7);
        send_byte(a0, 1'b0);
        send_byte(a1, 1'b0);
        send_byte(a2, 1'b0);
        send_byte(a3, 1'b0);
        send_byte(a4, 1'b0);
        send_byte(a5, 1'b0);
        send_byte(a6, 1'b0);
        send_byte(a7, 1'b1);
    endtask

    task automatic check_out(input string tag, input logic [7:0] m,
                             input logic [7:0] k0, input logic [7:0] k1,
                             input logic [7:0] k2, input logic [7:0] k3);
        check8({tag, "_mod"}, modifier, m);
        check8({tag, "_k0"}, keycode_0, k0);
        check8({tag, "_k1"}, keycode_1, k1);
        check8({tag, "_k2"}, keycode_2, k2);
        check8({tag, "_k3"}, keycode_3, k3);
    endtask

    task automatic clr;
        strobe_cnt = 0;
        err_cnt    = 0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        strobe_cnt  = 0;
        err_cnt     = 0;
        both_cnt    = 0;
        byte_in     = 8'h00;
        byte_valid  = 1'b0;
        byte_last   = 1'b0;
        Reset       = 1'b0;

        cycles(2);
        check_out("rst", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        check8("rst_ready", {7'd0, byte_ready}, 8'h01);
        check8("rst_strobe", {7'd0, report_strobe}, 8'h00);
        check8("rst_err", {7'd0, report_err}, 8'h00);
        Reset = 1'b1;
        cycles(1);

        // good report with exact latency
        clr();
        send8(8'h02, 8'h00, 8'h04, 8'h1A, 8'h16, 8'h07, 8'h00, 8'h00);
        check8("good_report_busy", {7'd0, byte_ready}, 8'h00);
        check8("good_no_strobe_yet", {7'd0, report_strobe}, 8'h00);
        cycles(1);
        check8("good_strobe", {7'd0, report_strobe}, 8'h01);
        check_out("good", 8'h02, 8'h04, 8'h1A, 8'h16, 8'h07);
        cycles(1);
        check8("good_strobe_off", {7'd0, report_strobe}, 8'h00);
        cycles(2);
        checkn("good_strobes", strobe_cnt, 1);
        checkn("good_errs", err_cnt, 0);

        // phantom report
        clr();
        send8(8'h00, 8'h00, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01);
        cycles(4);
        checkn("phantom_strobes", strobe_cnt, 0);
        checkn("phantom_errs", err_cnt, 1);
        check_out("phantom", 8'h02, 8'h04, 8'h1A, 8'h16, 8'h07);

        // short report
        clr();
        send_byte(8'h11, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        send_byte(8'h44, 1'b1);
        check8("short_err_pulse", {7'd0, report_err}, 8'h01);
        cycles(4);
        checkn("short_strobes", strobe_cnt, 0);
        checkn("short_errs", err_cnt, 1);
        check_out("short", 8'h02, 8'h04, 8'h1A, 8'h16, 8'h07);
        clr();
        send8(8'h01, 8'h00, 8'h05, 8'h06, 8'h07, 8'h08, 8'h00, 8'h00);
        cycles(3);
        checkn("after_short_strobes", strobe_cnt, 1);
        check_out("after_short", 8'h01, 8'h05, 8'h06, 8'h07, 8'h08);

        // long report
        clr();
        send_byte(8'h20, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h09, 1'b0);
        send_byte(8'h0A, 1'b0);
        send_byte(8'h0B, 1'b0);
        send_byte(8'h0C, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        cycles(2);
        checkn("long_drain_quiet", err_cnt + strobe_cnt, 0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b1);
        cycles(4);
        checkn("long_strobes", strobe_cnt, 0);
        checkn("long_errs", err_cnt, 1);
        check_out("long", 8'h01, 8'h05, 8'h06, 8'h07, 8'h08);

        // gap just under the timeout is tolerated
        clr();
        send_byte(8'h04, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h2A, 1'b0);
        cycles(TO - 3);
        send_byte(8'h2B, 1'b0);
        send_byte(8'h2C, 1'b0);
        send_byte(8'h2D, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b1);
        cycles(3);
        checkn("gap_errs", err_cnt, 0);
        checkn("gap_strobes", strobe_cnt, 1);
        check_out("gap", 8'h04, 8'h2A, 8'h2B, 8'h2C, 8'h2D);

        // timeout
        clr();
        send_byte(8'h55, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h30, 1'b0);
        cycles(TO + 4);
        checkn("timeout_errs", err_cnt, 1);
        checkn("timeout_strobes", strobe_cnt, 0);
        check_out("timeout", 8'h04, 8'h2A, 8'h2B, 8'h2C, 8'h2D);
        clr();
        send8(8'h08, 8'h00, 8'h31, 8'h32, 8'h33, 8'h34, 8'h00, 8'h00);
        cycles(3);
        checkn("after_to_strobes", strobe_cnt, 1);
        checkn("after_to_errs", err_cnt, 0);
        check_out("after_to", 8'h08, 8'h31, 8'h32, 8'h33, 8'h34);

        // reset mid-report
        send_byte(8'h66, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h50, 1'b0);
        send_byte(8'h51, 1'b0);
        send_byte(8'h52, 1'b0);
        Reset = 1'b0;
        #1;
        check_out("midrst", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        check8("midrst_ready", {7'd0, byte_ready}, 8'h01);
        cycles(2);
        #3;
        Reset = 1'b1;
        cycles(1);
        clr();
        send8(8'h03, 8'h00, 8'h41, 8'h42, 8'h43, 8'h44, 8'h00, 8'h00);
        cycles(3);
        checkn("after_rst_strobes", strobe_cnt, 1);
        checkn("after_rst_errs", err_cnt, 0);
        check_out("after_rst", 8'h03, 8'h41, 8'h42, 8'h43, 8'h44);

        checkn("never_both", both_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hid_keycode_rx.md
HID_KEYCODE_RX -- requirements
Module: hid_keycode_rx

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1023, the maximum idle cycles allowed between bytes inside one report.
REQ-002 SHALL have port Clk  input  1  system clock; all state changes on the rising edge.
REQ-003 SHALL have port Reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port byte_in  input  8  one HID boot-report byte.
REQ-005 SHALL have port byte_valid  input  1  byte_in is valid this cycle.
REQ-006 SHALL have port byte_last  input  1  qualifies byte_valid; marks the final byte of a report.
REQ-007 SHALL have port byte_ready  output  1  the block accepts a byte this cycle.
REQ-008 SHALL have port keycode_0, keycode_1, keycode_2, keycode_3  output  8 each  first four key slots of the last good report.
REQ-009 SHALL have port modifier  output  8  modifier byte of the last good report.
REQ-010 SHALL have port report_strobe  output  1  one-cycle pulse when the outputs are updated.
REQ-011 SHALL have port report_err  output  1  one-cycle pulse when a report is discarded.

Function
REQ-012 SHALL accept a byte only on cycles where byte_valid and byte_ready are both 1.
REQ-013 SHALL hold byte_ready at 1 in every state except REPORT.
REQ-014 SHALL use the states IDLE, COLLECT, DRAIN and REPORT, with a 3-bit byte index and a timeout counter.
REQ-015 SHALL treat an accepted byte in IDLE as byte 0 (modifier), set index to 1, and enter COLLECT; if byte_last is also set, it discards the report with report_err and stays in IDLE.
REQ-016 SHALL store byte 0 in a shadow register and ignore byte 1 (reserved).
REQ-017 SHALL store bytes 2-5 in shadow slots 0-3 and ignore bytes 6-7.
REQ-018 SHALL increment the index on each accepted byte in COLLECT.
REQ-019 SHALL enter REPORT when byte 7 is accepted with byte_last=1.
REQ-020 SHALL, when byte_last arrives at index <7 (short report), discard the report, pulse report_err the next cycle, and return to IDLE.
REQ-021 SHALL, when byte 7 is accepted without byte_last (long report), enter DRAIN.
REQ-022 SHALL, in DRAIN, accept and drop bytes until byte_last, then pulse report_err and return to IDLE.
REQ-023 SHALL, in REPORT (exactly one cycle), copy the shadow registers to modifier and keycode_0..3, pulse report_strobe, and return to IDLE.
REQ-024 SHALL treat a report as phantom (rollover) when shadow slots 0-3 all equal 8'h01.
REQ-025 SHALL, for a phantom report, leave the outputs unchanged and pulse report_err instead of report_strobe.
REQ-026 SHALL reset the timeout counter on every accepted byte and increment it on every other cycle in COLLECT or DRAIN.
REQ-027 SHALL, when the timeout counter reaches TIMEOUT_CYCLES, abort to IDLE and pulse report_err; a byte accepted in the same cycle starts a new report in IDLE.
REQ-028 SHALL never assert report_strobe and report_err in the same cycle.
REQ-029 SHALL drive keycode_* and modifier from registers, changing only in REPORT.

Reset
REQ-030 SHALL, on Reset=0 at any time including mid-report, immediately force the state to IDLE, the index and timeout counter to 0, all keycode_*, modifier and shadow registers to 8'h00, report_strobe and report_err to 0, and byte_ready to 1.
REQ-031 SHALL resume normal operation on the first rising Clk edge after Reset returns to 1, treating the next accepted byte as byte 0.

Verification
REQ-032 Good report: send 02 00 04 1A 16 07 00 00 with last on byte 7 -> one cycle later report_strobe=1, modifier=02, keycode_0..3=04,1A,16,07.
REQ-033 Phantom report: send 00 00 01 01 01 01 01 01 after a good report -> report_err pulse, outputs keep their previous values, no report_strobe.
REQ-034 Short report: send 5 bytes with last on byte 4 -> report_err pulse, outputs unchanged; the next full report decodes correctly.
REQ-035 Long report: send 10 bytes with last on byte 9 -> DRAIN entered after byte 7, a single report_err after byte 9, outputs unchanged.
REQ-036 Timeout: send 3 bytes, then idle for TIMEOUT_CYCLES cycles -> report_err pulse, state IDLE; the next byte is treated as modifier.
REQ-037 Reset mid-report: assert Reset=0 after byte 4 -> outputs immediately 00; after release, a full report decodes normally.
